// File: rtl/vid_pkg.sv
// Shared constants for the BT.601 RGB to YCbCr 4:2:2 converter: pixel width,
// intermediate sum width and per-channel coefficient/offset/clamp sets.
package vid_pkg;

    localparam int PIX_W = 8;
    localparam int SUM_W = 18;

    localparam logic [PIX_W-1:0] C_MID = 8'd128;

    typedef struct packed {
        int k_r;
        int k_g;
        int k_b;
        int offset;
        int lo;
        int hi;
    } chan_cfg_t;

    // Coefficients are x256 fixed point.
    localparam chan_cfg_t LIM_Y  = '{k_r:  66, k_g:  129, k_b:  25, offset:  16, lo: 16, hi: 235};
    localparam chan_cfg_t LIM_CB = '{k_r: -38, k_g:  -74, k_b: 112, offset: 128, lo: 16, hi: 240};
    localparam chan_cfg_t LIM_CR = '{k_r: 112, k_g:  -94, k_b: -18, offset: 128, lo: 16, hi: 240};

    localparam chan_cfg_t FULL_Y  = '{k_r:  77, k_g:  150, k_b:  29, offset:   0, lo: 0, hi: 255};
    localparam chan_cfg_t FULL_CB = '{k_r: -43, k_g:  -85, k_b: 128, offset: 128, lo: 0, hi: 255};
    localparam chan_cfg_t FULL_CR = '{k_r: 128, k_g: -107, k_b: -21, offset: 128, lo: 0, hi: 255};

    function automatic logic [PIX_W-1:0] black_level(input bit limited);
        return limited ? 8'd16 : 8'd0;
    endfunction

endpackage

// File: rtl/vid_csc_dot3.sv
// One colour-space channel: three products (S1), 3-term sum (S2),
// round/offset/clamp (S3). Three register stages from r/g/b to result.
module vid_csc_dot3
    import vid_pkg::*;
#(
    parameter chan_cfg_t CFG = LIM_Y
) (
    input  logic             clk,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] result
);

    localparam logic signed [SUM_W-1:0] K_R = SUM_W'(CFG.k_r);
    localparam logic signed [SUM_W-1:0] K_G = SUM_W'(CFG.k_g);
    localparam logic signed [SUM_W-1:0] K_B = SUM_W'(CFG.k_b);
    localparam logic signed [SUM_W-1:0] OFF = SUM_W'(CFG.offset);
    localparam logic signed [SUM_W-1:0] LO  = SUM_W'(CFG.lo);
    localparam logic signed [SUM_W-1:0] HI  = SUM_W'(CFG.hi);
    localparam logic signed [SUM_W-1:0] RND = 18'sd128;

    logic signed [SUM_W-1:0] r_s, g_s, b_s;
    logic signed [SUM_W-1:0] p_r, p_g, p_b;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] rnd, ofs;
    logic        [PIX_W-1:0] clamped;

    assign r_s = {{(SUM_W-PIX_W){1'b0}}, r};
    assign g_s = {{(SUM_W-PIX_W){1'b0}}, g};
    assign b_s = {{(SUM_W-PIX_W){1'b0}}, b};

    // NOTE: datapath registers carry no reset; the de delay line in the top
    // marks which stages hold real pixels, so stale data is never observed.
    // NOTE: sequential state uses <= so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        p_r   <= r_s * K_R;
        p_g   <= g_s * K_G;
        p_b   <= b_s * K_B;
        sum_q <= p_r + p_g + p_b;
    end

    // NOTE: clamped gets its default first so no path leaves it unassigned.
    always_comb begin
        rnd     = (sum_q + RND) >>> 8;
        ofs     = rnd + OFF;
        clamped = ofs[PIX_W-1:0];
        if (ofs < LO) begin
            clamped = LO[PIX_W-1:0];
        end else if (ofs > HI) begin
            clamped = HI[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        result <= clamped;
    end

endmodule

// File: rtl/vid_rgb2ycc422.sv
// BT.601 RGB to YCbCr 4:2:2 converter with matched timing delay line.
// Chroma is co-sited: Cb and Cr of each even pixel, odd-pixel chroma dropped.
module vid_rgb2ycc422
    import vid_pkg::*;
#(
    parameter  int RANGE_LIMITED = 1,
    localparam int LATENCY       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic             vid_de,
    input  logic [PIX_W-1:0] vid_r,
    input  logic [PIX_W-1:0] vid_g,
    input  logic [PIX_W-1:0] vid_b,
    output logic             out_hs,
    output logic             out_vs,
    output logic             out_de,
    output logic [PIX_W-1:0] out_y,
    output logic [PIX_W-1:0] out_c,
    output logic             out_c_is_cr
);

    localparam bit               LIM   = (RANGE_LIMITED != 0);
    localparam chan_cfg_t        CFG_Y  = LIM ? LIM_Y  : FULL_Y;
    localparam chan_cfg_t        CFG_CB = LIM ? LIM_CB : FULL_CB;
    localparam chan_cfg_t        CFG_CR = LIM ? LIM_CR : FULL_CR;
    localparam logic [PIX_W-1:0] BLACK = black_level(LIM);

    logic [PIX_W-1:0] y_s3, cb_s3, cr_s3;
    logic [PIX_W-1:0] cr_hold;
    logic [LATENCY-1:0] hs_d, vs_d, de_d;
    logic s3_de, s3_rise, phase, cur_phase;

    vid_csc_dot3 #(.CFG(CFG_Y)) u_y (
        .clk(clk), .r(vid_r), .g(vid_g), .b(vid_b), .result(y_s3)
    );

    vid_csc_dot3 #(.CFG(CFG_CB)) u_cb (
        .clk(clk), .r(vid_r), .g(vid_g), .b(vid_b), .result(cb_s3)
    );

    vid_csc_dot3 #(.CFG(CFG_CR)) u_cr (
        .clk(clk), .r(vid_r), .g(vid_g), .b(vid_b), .result(cr_s3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d <= '1;
            vs_d <= '1;
            de_d <= '0;
        end else begin
            hs_d <= {hs_d[LATENCY-2:0], vid_hs};
            vs_d <= {vs_d[LATENCY-2:0], vid_vs};
            de_d <= {de_d[LATENCY-2:0], vid_de};
        end
    end

    assign out_hs = hs_d[LATENCY-1];
    assign out_vs = vs_d[LATENCY-1];
    assign out_de = de_d[LATENCY-1];

    // de_d[LATENCY-1] is the previous S3 de, so a line start is a 0->1 step.
    assign s3_de     = de_d[LATENCY-2];
    assign s3_rise   = s3_de & ~de_d[LATENCY-1];
    assign cur_phase = s3_rise ? 1'b0 : phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= 1'b0;
            out_y       <= BLACK;
            out_c       <= C_MID;
            out_c_is_cr <= 1'b0;
        end else if (s3_de) begin
            phase       <= ~cur_phase;
            out_y       <= y_s3;
            out_c       <= cur_phase ? cr_hold : cb_s3;
            out_c_is_cr <= cur_phase;
        end else begin
            phase       <= 1'b0;
            out_y       <= BLACK;
            out_c       <= C_MID;
            out_c_is_cr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s3_de && !cur_phase) begin
            cr_hold <= cr_s3;
        end
    end

endmodule

// File: tb/tb_vid_rgb2ycc422.sv
// Scoreboard bench: limited- and full-range instances share one directed
// stimulus stream; expected outputs are queued with their due cycle.
module tb_vid_rgb2ycc422;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vid_hs = 1'b1, vid_vs = 1'b1, vid_de = 1'b0;
    logic [7:0] vid_r = 8'd0, vid_g = 8'd0, vid_b = 8'd0;

    logic       l_hs, l_vs, l_de, l_cr;
    logic [7:0] l_y, l_c;
    logic       f_hs, f_vs, f_de, f_cr;
    logic [7:0] f_y, f_c;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vid_rgb2ycc422 #(.RANGE_LIMITED(1)) dut_lim (
        .clk(clk), .reset(reset),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .out_hs(l_hs), .out_vs(l_vs), .out_de(l_de),
        .out_y(l_y), .out_c(l_c), .out_c_is_cr(l_cr)
    );

    vid_rgb2ycc422 #(.RANGE_LIMITED(0)) dut_full (
        .clk(clk), .reset(reset),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .out_hs(f_hs), .out_vs(f_vs), .out_de(f_de),
        .out_y(f_y), .out_c(f_c), .out_c_is_cr(f_cr)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic [7:0] yl, cbl, crl;
        logic [7:0] yf, cbf, crf;
    } col_t;

    typedef struct {
        int         due;
        logic       hs, vs, de, is_cr;
        logic [7:0] yl, cl, yf, cf;
    } exp_t;

    col_t pal[6];
    exp_t q[$];

    bit         m_phase = 1'b0;
    bit         m_prev_de = 1'b0;
    logic [7:0] m_crl = 8'd0, m_crf = 8'd0;

    localparam int K = 0, W = 1, R = 2, B = 3, G = 4, M = 5;

    initial begin
        // r, g, b, Y/Cb/Cr limited, Y/Cb/Cr full -- hand computed
        pal[K] = '{8'd0,   8'd0,   8'd0,   8'd16,  8'd128, 8'd128, 8'd0,   8'd128, 8'd128};
        pal[W] = '{8'd255, 8'd255, 8'd255, 8'd235, 8'd128, 8'd128, 8'd255, 8'd128, 8'd128};
        pal[R] = '{8'd255, 8'd0,   8'd0,   8'd82,  8'd90,  8'd240, 8'd77,  8'd85,  8'd255};
        pal[B] = '{8'd0,   8'd0,   8'd255, 8'd41,  8'd240, 8'd110, 8'd29,  8'd255, 8'd107};
        pal[G] = '{8'd0,   8'd255, 8'd0,   8'd144, 8'd54,  8'd34,  8'd149, 8'd43,  8'd21};
        pal[M] = '{8'd128, 8'd64,  8'd32,  8'd84,  8'd105, 8'd158, 8'd80,  8'd101, 8'd163};
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t idle_rec(input int due, input logic hs, input logic vs);
        exp_t e;
        e.due = due; e.hs = hs; e.vs = vs; e.de = 1'b0; e.is_cr = 1'b0;
        e.yl = 8'd16; e.yf = 8'd0; e.cl = 8'd128; e.cf = 8'd128;
        return e;
    endfunction

    // One input cycle, sampled at the next clk edge; result due 4 cycles on.
    task automatic drive(input logic rst, input logic hs, input logic vs,
                         input logic de, input int ci);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        vid_hs = hs;
        vid_vs = vs;
        vid_de = de;
        vid_r  = de ? pal[ci].r : 8'h5a;
        vid_g  = de ? pal[ci].g : 8'ha5;
        vid_b  = de ? pal[ci].b : 8'h3c;
        if (rst) begin
            e = idle_rec(cyc + 4, 1'b1, 1'b1);
            foreach (q[i]) begin
                if (q[i].due > cyc) q[i] = idle_rec(q[i].due, 1'b1, 1'b1);
            end
            m_prev_de = 1'b0;
        end else if (de) begin
            if (!m_prev_de) m_phase = 1'b0;
            e.due = cyc + 4; e.hs = hs; e.vs = vs; e.de = 1'b1;
            e.yl = pal[ci].yl; e.yf = pal[ci].yf;
            e.is_cr = m_phase;
            e.cl = m_phase ? m_crl : pal[ci].cbl;
            e.cf = m_phase ? m_crf : pal[ci].cbf;
            if (!m_phase) begin
                m_crl = pal[ci].crl;
                m_crf = pal[ci].crf;
            end
            m_phase = ~m_phase;
            m_prev_de = 1'b1;
        end else begin
            e = idle_rec(cyc + 4, hs, vs);
            m_prev_de = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic line(input int px[$]);
        foreach (px[i]) drive(1'b0, 1'b1, 1'b1, 1'b1, px[i]);
    endtask

    task automatic gap(input int n);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        repeat (n - 1) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL order: record due %0d still queued at cycle %0d", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            check("lim_hs", {7'd0, l_hs}, {7'd0, e.hs});
            check("lim_vs", {7'd0, l_vs}, {7'd0, e.vs});
            check("lim_de", {7'd0, l_de}, {7'd0, e.de});
            check("lim_y", l_y, e.yl);
            check("lim_c", l_c, e.cl);
            check("lim_is_cr", {7'd0, l_cr}, {7'd0, e.is_cr});
            check("full_hs", {7'd0, f_hs}, {7'd0, e.hs});
            check("full_vs", {7'd0, f_vs}, {7'd0, e.vs});
            check("full_de", {7'd0, f_de}, {7'd0, e.de});
            check("full_y", f_y, e.yf);
            check("full_c", f_c, e.cf);
            check("full_is_cr", {7'd0, f_cr}, {7'd0, e.is_cr});
        end
    end

    initial begin
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        gap(2);
        line('{K, K, W, W});
        gap(2);
        line('{R, R, M, G});
        gap(2);
        line('{R, G, B});
        gap(2);
        line('{M, W});
        gap(1);
        line('{B, B});
        gap(1);
        line('{W, R, G});
        drive(1'b1, 1'b1, 1'b1, 1'b1, G);
        line('{B, M, W});
        gap(6);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d records left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
